pc_fetch_ctrl: RTL
==================

// Module: pc_fetch_ctrl
// PURPOSE
//  Fetch-stage sequencer. Owns the fetch PC and drives a sram-like instruction port
//  (req/addr_ok/data_ok), one transaction outstanding at a time.
//  Merges back-end redirects (eret > exc > pmis > jump) into the fetch PC, cancelling
//  any in-flight fetch. Hands one instruction at a time to decode under a stall handshake.
// PARAMETERS
//  WIDTH     32            address/data width
//  RESET_PC  32'hbfc00000  first fetch address after reset
// PORTS
//  clk          in   1      clock, all logic on posedge
//  rst_n        in   1      synchronous reset, active-low
//  stall        in   1      decode cannot accept this cycle
//  eret/exc/pmis/jump in 1 each   redirect requests, single-cycle pulses
//  pc_eret/pc_exc/pc_pmis/pc_jump in WIDTH each   redirect targets
//  inst_req     out  1      instruction request
//  inst_addr    out  WIDTH  request address (= fetch_pc)
//  inst_addr_ok in   1      request accepted this cycle
//  inst_data_ok in   1      read data returned this cycle
//  inst_rdata   in   WIDTH  read data
//  if_valid     out  1      if_pc/if_inst hold a live instruction
//  if_pc        out  WIDTH  PC of offered instruction
//  if_inst      out  WIDTH  offered instruction
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge), applied from any state, even mid-transaction:
//    state=IDLE, fetch_pc=RESET_PC, cancel=0, inst_req=0, if_valid=0, if_pc=RESET_PC,
//    if_inst=0. Any later data_ok belonging to a pre-reset request is ignored.
//  - redir = eret|exc|pmis|jump. Target chosen by fixed priority eret>exc>pmis>jump.
//  - States:
//    IDLE: -> REQ next cycle. A redirect here loads fetch_pc=target.
//    REQ: inst_req=1.
//      - inst_addr is held stable until inst_addr_ok; it is never changed while
//        req=1 && addr_ok=0.
//      - addr_ok -> WAIT.
//    WAIT: inst_req=0.
//      - data_ok && cancel: discard data, cancel<=0, fetch_pc<=pend_target -> REQ.
//      - data_ok && !cancel: if_inst<=rdata, if_pc<=fetch_pc, if_valid<=1 -> HOLD.
//      - data_ok is never expected in the same cycle as addr_ok.
//    HOLD: if_valid=1.
//      - !stall: instruction consumed; fetch_pc<=fetch_pc+4 (mod 2^WIDTH, wraps),
//        if_valid<=0 -> REQ.
//      - stall: hold all outputs.
//  - Redirect in REQ or WAIT:
//    - cancel<=1 and pend_target<=target; fetch_pc stays unchanged until the
//      transaction ends.
//    - A later redirect before completion overwrites pend_target (latest wins).
//    - Redirect coinciding with data_ok: the data is discarded and the next REQ
//      uses the new target.
//  - Redirect in HOLD:
//    - Same cycle: if !stall the held instruction counts as consumed (delay slot);
//      if stall it is dropped. Either way if_valid<=0, fetch_pc<=target -> REQ.
//  - Redirect in IDLE: fetch_pc<=target.
//  - Latencies:
//    - First request: inst_req high in the 1st cycle after reset is released.
//    - Data: if_valid rises the cycle after data_ok.
//    - Next request: inst_req rises the cycle after consume or redirect.
//  - Targets are not alignment-checked; they pass through unchanged.
//  - Outputs are registered; no combinational path from redirect inputs to inst_addr.
// TESTING
//  1. Reset release; addr_ok=1 on first req; data_ok next cycle with rdata=32'h24020001,
//     stall=0 -> req@bfc00000, then if_valid=1 if_pc=bfc00000, then req@bfc00004.
//  2. HOLD with stall=1 for 3 cycles -> if_valid/if_pc/if_inst stable; inst_req=0;
//     stall drop -> req@+4 next cycle.
//  3. jump pulse (pc_jump=bfc00100) while in WAIT:
//     - The returned data is not presented (if_valid stays 0).
//     - The next req is @bfc00100.
//  4. jump and exc in the same cycle in REQ with addr_ok=0:
//     - inst_addr stays unchanged until accepted.
//     - Data is dropped.
//     - The next req is @pc_exc (bfc00380).
//  5. Redirect in HOLD, stall=0 vs stall=1:
//     - Either way the next req is @target and if_valid=0 the following cycle.
//     - The stall=0 case counts one consumed instruction.
//  6. fetch_pc=32'hfffffffc consumed -> next req @32'h00000000;
//     rst_n=0 during WAIT -> stale data_ok ignored, next req @RESET_PC.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, runs one outstanding transaction on a
// req/addr_ok/data_ok instruction port, and folds back-end redirects into the PC.
module pc_fetch_ctrl #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'hbfc00000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             eret,
    input  logic             exc,
    input  logic             pmis,
    input  logic             jump,
    input  logic [WIDTH-1:0] pc_eret,
    input  logic [WIDTH-1:0] pc_exc,
    input  logic [WIDTH-1:0] pc_pmis,
    input  logic [WIDTH-1:0] pc_jump,
    output logic             inst_req,
    output logic [WIDTH-1:0] inst_addr,
    input  logic             inst_addr_ok,
    input  logic             inst_data_ok,
    input  logic [WIDTH-1:0] inst_rdata,
    output logic             if_valid,
    output logic [WIDTH-1:0] if_pc,
    output logic [WIDTH-1:0] if_inst
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [WIDTH-1:0] pend_target_q, pend_target_d;
    logic             cancel_q, cancel_d;
    logic             if_valid_q, if_valid_d;
    logic [WIDTH-1:0] if_pc_q, if_pc_d;
    logic [WIDTH-1:0] if_inst_q, if_inst_d;

    logic             redir;
    logic [WIDTH-1:0] target;

    always_comb begin
        redir  = eret | exc | pmis | jump;
        target = eret ? pc_eret :
                 exc  ? pc_exc  :
                 pmis ? pc_pmis : pc_jump;
    end

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        pend_target_d = pend_target_q;
        cancel_d      = cancel_q;
        if_valid_d    = if_valid_q;
        if_pc_d       = if_pc_q;
        if_inst_d     = if_inst_q;
        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (redir) fetch_pc_d = target;
            end
            REQ: begin
                // The address on the bus must not move until accepted, so the
                // redirect is parked and applied once this transaction drains.
                if (redir) begin
                    cancel_d      = 1'b1;
                    pend_target_d = target;
                end
                if (inst_addr_ok) state_d = WAIT;
            end
            WAIT: begin
                if (inst_data_ok) begin
                    if (redir) begin
                        fetch_pc_d = target;
                        cancel_d   = 1'b0;
                        state_d    = REQ;
                    end else if (cancel_q) begin
                        fetch_pc_d = pend_target_q;
                        cancel_d   = 1'b0;
                        state_d    = REQ;
                    end else begin
                        if_inst_d  = inst_rdata;
                        if_pc_d    = fetch_pc_q;
                        if_valid_d = 1'b1;
                        state_d    = HOLD;
                    end
                end else if (redir) begin
                    cancel_d      = 1'b1;
                    pend_target_d = target;
                end
            end
            HOLD: begin
                if (redir) begin
                    if_valid_d = 1'b0;
                    fetch_pc_d = target;
                    state_d    = REQ;
                end else if (!stall) begin
                    if_valid_d = 1'b0;
                    fetch_pc_d = fetch_pc_q + WIDTH'(4);
                    state_d    = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            fetch_pc_q    <= RESET_PC;
            pend_target_q <= RESET_PC;
            cancel_q      <= 1'b0;
            if_valid_q    <= 1'b0;
            if_pc_q       <= RESET_PC;
            if_inst_q     <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            pend_target_q <= pend_target_d;
            cancel_q      <= cancel_d;
            if_valid_q    <= if_valid_d;
            if_pc_q       <= if_pc_d;
            if_inst_q     <= if_inst_d;
        end
    end

    assign inst_req  = (state_q == REQ);
    assign inst_addr = fetch_pc_q;
    assign if_valid  = if_valid_q;
    assign if_pc     = if_pc_q;
    assign if_inst   = if_inst_q;

endmodule
